arbitro_rr16: RTL and testbench
===============================

Name: arbitro_rr16

Overview:
- Round-robin arbiter that shares one 16-way resource between 16 requesters.
- Grants are non-preemptive: a requester keeps its grant for as long as it holds its request line.
- The winning index is registered as 4 bits and expanded to a one-hot grant vector through the team's 4-to-16 decoder, decod16.
- Sits in front of any shared datapath slot; downstream selects by gnt_idx or gnt.

Parameters:
- HOLD_MAX, default 8: maximum grant length in cycles. Used only when ARB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  16  request lines; req[i]=1 means requester i wants the resource or is still using it.
- gnt  output  16  one-hot grant; all zeros when gnt_valid=0.
- gnt_idx  output  4  index of the current or last granted requester.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked. Tied to 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset values (next edge with reset=1):
  - state=IDLE, ptr=0, gnt_idx=0, gnt_valid=0, gnt=16'h0000, timeout=0, hold counter=0.
  - Reset overrides everything, including an active grant. In that case gnt drops at that same edge.
- States: IDLE and BUSY.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first i with req[i]=1, scanning from ptr upward: ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
  - At the next edge: gnt_idx<=i, gnt_valid<=1, state<=BUSY.
  - Latency: a request sampled at edge k produces a grant visible after edge k (one cycle).
- BUSY:
  - While req[gnt_idx]=1, hold gnt_idx and gnt_valid.
  - Other requests are ignored; there is no preemption.
  - When req[gnt_idx]=0 is sampled, the next edge sets gnt_valid<=0, ptr<=gnt_idx+1 (4-bit wrap, 15→0) and state<=IDLE.
- Dead cycle: there is always exactly one IDLE cycle between consecutive grants. The maximum grant rate is therefore one grant per 2 cycles when each requester holds for 1 cycle.
- gnt_idx holds its last value while IDLE. gnt = decod16(gnt_idx) AND {16{gnt_valid}}.
- gnt is derived only from registers, with no combinational path from req.
- Requests that drop before being granted are simply lost; no queueing.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: an 8-bit hold counter clears on entry to BUSY and increments each BUSY cycle.
  - If the counter reaches HOLD_MAX-1 with req[gnt_idx] still 1, the next edge forces gnt_valid<=0, ptr<=gnt_idx+1, state<=IDLE and timeout<=1.
  - timeout lasts 1 cycle. gnt_valid is therefore high for at most HOLD_MAX cycles.
  - A requester still asserting req competes again from the new ptr.
  - A normal release in the same cycle the limit is reached takes precedence: timeout stays 0.
- Not defined: no counter is built, timeout is constant 0, and grants are unbounded.

Decomposition:
- Package arbitro_pkg holds:
  - N_REQ=16 and IDX_W=4.
  - typedef enum logic {IDLE, BUSY} arb_state_t.
  - typedef logic [IDX_W-1:0] arb_idx_t.
- One sub-module: decod16 (existing 4-to-16 decoder), instantiated once to produce gnt from gnt_idx.
- The priority scan stays in arbitro_rr16 as a function or for-loop.

Test Plan:
- Reset, then req=16'h0000 for 5 cycles → gnt=0, gnt_valid=0, gnt_idx=0 throughout.
- From ptr=0, req=16'h0011 held 3 cycles then req[0] dropped → gnt=16'h0001 for 3 cycles, one dead cycle, then gnt=16'h0010 with gnt_idx=4.
- Fairness: all 16 req held high, each requester drops its req 1 cycle after being granted → grant order 0,1,...,15,0, each grant separated by one dead cycle.
- Wrap: after a grant to 15 is released, req=16'h8001 → next gnt_idx=0 (ptr wrapped to 0), not 15.
- Reset mid-grant: gnt_idx=7 active, assert reset for 1 cycle → gnt=0 after that edge. With req=16'h0180 held, the next grant is gnt_idx=7 (ptr=0 scan hits 7 first).
- ARB_TIMEOUT_EN with HOLD_MAX=4: req=16'h0006 held forever → gnt_idx=1 for exactly 4 cycles and timeout=1 for 1 cycle, then gnt_idx=2 for 4 cycles, and so on. Without the macro, gnt_idx=1 holds indefinitely and timeout stays 0.

Source files
------------

// File: rtl/arbitro_pkg.sv
// ---------------------------------------------------------------------------
// arbitro_pkg : shared types and sizes for the 16-way round-robin arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arbitro_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic [IDX_W-1:0] arb_idx_t;

endpackage

`default_nettype wire

// File: rtl/arbitro_rr16_decod16.sv
// ---------------------------------------------------------------------------
// decod16 : 4-to-16 one-hot decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decod16 (
  input  logic [3:0]  sel,
  output logic [15:0] dec
);

  for (genvar i = 0; i < 16; i++) begin : g_dec
    assign dec[i] = (sel == 4'(i));
  end

endmodule

`default_nettype wire

// File: rtl/arbitro_rr16.sv
// ---------------------------------------------------------------------------
// arbitro_rr16 : non-preemptive 16-way round-robin arbiter, registered grant.
// Optional ARB_TIMEOUT_EN bounds each grant to HOLD_MAX cycles.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arbitro_rr16
  import arbitro_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_check
    $error("arbitro_rr16: HOLD_MAX must be in 1..255");
  end

  arb_state_t       state_q, state_d;
  arb_idx_t         ptr_q, ptr_d;
  arb_idx_t         idx_q, idx_d;
  logic [N_REQ-1:0] dec_w;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
`endif

  // First requester at or after p, wrapping modulo 16.
  function automatic arb_idx_t rr_pick(input logic [N_REQ-1:0] r, input arb_idx_t p);
    arb_idx_t pick;
    arb_idx_t cand;
    logic     found;
    pick  = p;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = p + arb_idx_t'(k);
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          idx_d   = rr_pick(req, ptr_q);
          state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      BUSY: begin
        // A normal release wins over a timeout landing on the same cycle.
        if (!req[idx_q]) begin
          state_d = IDLE;
          ptr_d   = idx_q + arb_idx_t'(1);
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == C_HOLD_LAST) begin
          state_d   = IDLE;
          ptr_d     = idx_q + arb_idx_t'(1);
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  decod16 u_decod16 (
    .sel (idx_q),
    .dec (dec_w)
  );

  always_comb begin
    gnt_valid = (state_q == BUSY);
    gnt_idx   = idx_q;
    gnt       = dec_w & {N_REQ{gnt_valid}};
`ifdef ARB_TIMEOUT_EN
    timeout   = timeout_q;
`else
    timeout   = 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_arbitro_rr16.sv
// ---------------------------------------------------------------------------
// tb_arbitro_rr16 : directed self-checking bench for arbitro_rr16
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_arbitro_rr16;

  logic        clk;
  logic        reset;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int checks;
  int failures;

  arbitro_rr16 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] eg, input logic [3:0] ei,
                     input logic ev, input logic et);
    checks++;
    assert ({gnt, gnt_idx, gnt_valid, timeout} === {eg, ei, ev, et})
    else begin
      failures++;
      $error("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, expected gnt=%h idx=%0d valid=%b timeout=%b",
             tag, gnt, gnt_idx, gnt_valid, timeout, eg, ei, ev, et);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    req      = 16'h0000;

    step(); chk("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step(); chk("idle_no_req", 16'h0000, 4'd0, 1'b0, 1'b0);
    end

    // Two requesters from ptr=0: 0 wins, then 4 after one dead cycle.
    req = 16'h0011;
    for (int i = 0; i < 3; i++) begin
      step(); chk("hold_gnt0", 16'h0001, 4'd0, 1'b1, 1'b0);
    end
    req = 16'h0010;
    step(); chk("dead_after0", 16'h0000, 4'd0, 1'b0, 1'b0);
    step(); chk("gnt4", 16'h0010, 4'd4, 1'b1, 1'b0);
    req = 16'h0000;
    step(); chk("release4", 16'h0000, 4'd4, 1'b0, 1'b0);

    // Fairness sweep from a fresh pointer.
    reset = 1'b1;
    step(); chk("reset2", 16'h0000, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    req = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      step(); chk("rr_grant", 16'(1 << i), 4'(i), 1'b1, 1'b0);
      req[i] = 1'b0;
      step(); chk("rr_dead", 16'h0000, 4'(i), 1'b0, 1'b0);
      req[i] = 1'b1;
    end
    step(); chk("rr_wrap0", 16'h0001, 4'd0, 1'b1, 1'b0);

    // Pointer wrap after releasing requester 15.
    req = 16'h0000;
    step(); chk("rel0", 16'h0000, 4'd0, 1'b0, 1'b0);
    req = 16'h8000;
    step(); chk("gnt15", 16'h8000, 4'd15, 1'b1, 1'b0);
    req = 16'h0000;
    step(); chk("rel15", 16'h0000, 4'd15, 1'b0, 1'b0);
    req = 16'h8001;
    step(); chk("wrap_gnt0", 16'h0001, 4'd0, 1'b1, 1'b0);

    // Reset in the middle of a grant to 7.
    req = 16'h0000;
    step(); chk("rel0b", 16'h0000, 4'd0, 1'b0, 1'b0);
    req = 16'h0080;
    step(); chk("gnt7", 16'h0080, 4'd7, 1'b1, 1'b0);
    reset = 1'b1;
    req   = 16'h0180;
    step(); chk("reset_mid", 16'h0000, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step(); chk("post_reset_gnt7", 16'h0080, 4'd7, 1'b1, 1'b0);
    step(); chk("post_reset_hold7", 16'h0080, 4'd7, 1'b1, 1'b0);
    req = 16'h0000;
    step(); chk("rel7", 16'h0000, 4'd7, 1'b0, 1'b0);

    // Long-held requests 1 and 2 (pointer now 8).
    req = 16'h0006;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step(); chk("to_gnt1", 16'h0002, 4'd1, 1'b1, 1'b0);
    end
    step(); chk("to_pulse1", 16'h0000, 4'd1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(); chk("to_gnt2", 16'h0004, 4'd2, 1'b1, 1'b0);
    end
    step(); chk("to_pulse2", 16'h0000, 4'd2, 1'b0, 1'b1);
    step(); chk("to_regnt1", 16'h0002, 4'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); chk("to_regnt1_hold", 16'h0002, 4'd1, 1'b1, 1'b0);
    end
    // Release on the limit cycle: no timeout pulse.
    req = 16'h0004;
    step(); chk("release_at_limit", 16'h0000, 4'd1, 1'b0, 1'b0);
`else
    for (int i = 0; i < 10; i++) begin
      step(); chk("no_timeout_hold1", 16'h0002, 4'd1, 1'b1, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
